ddr_burst_sequencer: RTL and testbench
======================================

// Module: ddr_burst_sequencer
// PURPOSE
//  Drives the DDR2 user command/data port on behalf of the memory data path. Arbitrates
//  write bursts (from write FIFO) and read bursts (into read FIFO), one 32-bit word per command.
//  Emits rd_addr_up / wr_addr_up pulses that step the address generator by 4 bytes per command.
//  Sits between the write/read FIFOs, the address generator and the DDR2 controller.
// PARAMETERS
//  ADDR_W     24  byte address width (matches address generator)
//  DATA_W     32  word width, one word per command
//  BURST_LEN  8   commands per grant before re-arbitration (power of 2, >=2)
// PORTS
//  clk            in   1       system clock
//  reset          in   1       async active-low reset
//  ddr_vaild      in   1       restart: address generator reloads; sequencer aborts to IDLE
//  wr_req         in   1       write FIFO holds >= BURST_LEN words
//  wr_fifo_empty  in   1       write FIFO empty
//  wr_fifo_data   in   DATA_W  write FIFO head word
//  wr_fifo_rd     out  1       pop write FIFO (1-cycle pulse per word)
//  rd_req         in   1       read FIFO has >= BURST_LEN free entries
//  rd_fifo_wr     out  1       push rd_fifo_data into read FIFO
//  rd_fifo_data   out  DATA_W  read word
//  rd_addr        in   ADDR_W  current read address
//  wr_addr        in   ADDR_W  current write address
//  rd_addr_up     out  1       read address +4 (1 cycle per accepted read cmd)
//  wr_addr_up     out  1       write address +4 (1 cycle per accepted write cmd)
//  cmd_en         out  1       command valid to DDR controller
//  cmd_instr      out  3       3'b000 write, 3'b001 read
//  cmd_addr       out  ADDR_W  command byte address
//  cmd_rdy        in   1       controller accepts command when cmd_en&cmd_rdy
//  wdf_en         out  1       write data valid
//  wdf_data       out  DATA_W  write data
//  wdf_rdy        in   1       controller accepts data when wdf_en&wdf_rdy
//  rdata          in   DATA_W  read data
//  rdata_valid    in   1       read data strobe
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; burst count 0; last_grant = READ (first grant is write).
//  States: IDLE, WR_DATA, WR_CMD, RD_CMD, RD_WAIT.
//  IDLE: wr_req&rd_req -> grant opposite of last_grant; only one -> that one; none -> stay.
//   Grant WR -> WR_DATA; grant RD -> RD_CMD; count cleared, last_grant updated.
//  WR_DATA: wdf_en = ~wr_fifo_empty, wdf_data = wr_fifo_data; on wdf_en&wdf_rdy:
//   wr_fifo_rd pulses same cycle, -> WR_CMD. FIFO empty -> hold, wdf_en low.
//  WR_CMD: cmd_en=1, cmd_instr=000, cmd_addr=wr_addr; on cmd_rdy: wr_addr_up pulses same
//   cycle, count++; count was BURST_LEN-1 -> IDLE, else -> WR_DATA.
//  RD_CMD: cmd_en=1, cmd_instr=001, cmd_addr=rd_addr; on cmd_rdy: rd_addr_up pulses, -> RD_WAIT.
//  RD_WAIT: on rdata_valid: rd_fifo_wr=1, rd_fifo_data=rdata (same cycle, combinational
//   pass-through), count++; last word -> IDLE else -> RD_CMD. One read outstanding max.
//  cmd_en/wdf_en/cmd_addr hold stable until accepted; no addr_up without handshake.
//  Address up pulses never coincide with each other; at most one per cycle.
//  ddr_vaild=1 in any state: next state IDLE, count 0; cmd_en, wdf_en, addr_up and
//   fifo strobes forced 0 that cycle (handshake in that cycle discarded); rdata_valid
//   arriving after abort is dropped (no rd_fifo_wr while in IDLE).
//  Count width $clog2(BURST_LEN); wraps to 0 only via IDLE reload.
//  Reset asserted mid-burst: immediate IDLE, outputs 0, no partial completion.
// STRUCTURE
//  Shared package/header: state encodings, CMD_WR=3'b000, CMD_RD=3'b001, GRANT_WR/GRANT_RD.
//  State/count/last_grant flops via sirv_gnrl_dfflr-style flops (async active-low).
//  One sub-module natural: ddr_rr_arb (2-requester round-robin, last_grant register).
// TESTING
//  1 Reset, wr_req=1, rd_req=0, cmd_rdy=wdf_rdy=1 -> 8 wr_fifo_rd, 8 wr_addr_up, cmd_addr
//    0x000000..0x00001C when addr gen starts at 0; IDLE after 8th accept.
//  2 wr_req=rd_req=1 continuously -> grants alternate W,R,W,R; 8 cmds each; first is W.
//  3 cmd_rdy low 5 cycles in WR_CMD -> cmd_en/cmd_addr stable, no wr_addr_up until accept.
//  4 Read burst, rdata_valid 3 cycles after each accept, rdata=0xA5A50000+n ->
//    8 rd_fifo_wr with matching data, rd_addr_up never >1 outstanding.
//  5 wr_fifo_empty=1 for 4 cycles mid-burst -> wdf_en low, burst resumes, total 8 words.
//  6 ddr_vaild pulse in RD_WAIT then late rdata_valid -> IDLE, no rd_fifo_wr, no addr_up.

Source files
------------

// File: rtl/ddr_burst_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// ddr_burst_sequencer_pkg
//   Shared definitions for the DDR2 burst sequencer: bus widths, DDR command
//   encodings, sequencer state encoding and arbiter grant encoding.
// ---------------------------------------------------------------------------
package ddr_burst_sequencer_pkg;

   localparam int ADDR_W = 24;   // byte address width, matches address generator
   localparam int DATA_W = 32;   // one word per DDR command

   localparam logic [2:0] CMD_WR = 3'b000;
   localparam logic [2:0] CMD_RD = 3'b001;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WR_DATA = 3'd1,
      ST_WR_CMD  = 3'd2,
      ST_RD_CMD  = 3'd3,
      ST_RD_WAIT = 3'd4
   } state_e;

   typedef enum logic {
      GRANT_WR = 1'b0,
      GRANT_RD = 1'b1
   } grant_e;

endpackage

// File: rtl/ddr_burst_sequencer_if.sv
// ---------------------------------------------------------------------------
// ddr_burst_sequencer_if
//   Bundles every non-clock signal of the sequencer: write/read FIFO side,
//   address generator side and DDR2 controller user port.
//   master : the sequencer (drives FIFO strobes, addr_up pulses, cmd/wdf)
//   slave  : the surrounding data path and controller
// ---------------------------------------------------------------------------
interface ddr_burst_sequencer_if;
   import ddr_burst_sequencer_pkg::*;

   // restart / FIFO side
   logic              ddr_vaild;
   logic              wr_req;
   logic              wr_fifo_empty;
   logic [DATA_W-1:0] wr_fifo_data;
   logic              wr_fifo_rd;
   logic              rd_req;
   logic              rd_fifo_wr;
   logic [DATA_W-1:0] rd_fifo_data;
   // address generator side
   logic [ADDR_W-1:0] rd_addr;
   logic [ADDR_W-1:0] wr_addr;
   logic              rd_addr_up;
   logic              wr_addr_up;
   // DDR controller side
   logic              cmd_en;
   logic [2:0]        cmd_instr;
   logic [ADDR_W-1:0] cmd_addr;
   logic              cmd_rdy;
   logic              wdf_en;
   logic [DATA_W-1:0] wdf_data;
   logic              wdf_rdy;
   logic [DATA_W-1:0] rdata;
   logic              rdata_valid;

   modport master (
      input  ddr_vaild, wr_req, wr_fifo_empty, wr_fifo_data, rd_req,
             rd_addr, wr_addr, cmd_rdy, wdf_rdy, rdata, rdata_valid,
      output wr_fifo_rd, rd_fifo_wr, rd_fifo_data, rd_addr_up, wr_addr_up,
             cmd_en, cmd_instr, cmd_addr, wdf_en, wdf_data
   );

   modport slave (
      output ddr_vaild, wr_req, wr_fifo_empty, wr_fifo_data, rd_req,
             rd_addr, wr_addr, cmd_rdy, wdf_rdy, rdata, rdata_valid,
      input  wr_fifo_rd, rd_fifo_wr, rd_fifo_data, rd_addr_up, wr_addr_up,
             cmd_en, cmd_instr, cmd_addr, wdf_en, wdf_data
   );

endinterface

// File: rtl/ddr_burst_sequencer_arb.sv
// ---------------------------------------------------------------------------
// ddr_rr_arb
//   Two-requester round-robin arbiter (write vs read). When both request,
//   the grant goes to the side that did not win last time. last_grant resets
//   to READ so the very first contended grant is a write.
//   Ports:
//     clk, reset      clock, async active-low reset
//     i_wr_req        write requester
//     i_rd_req        read requester
//     i_take          sequencer consumes the grant this cycle
//     o_valid         some requester is active
//     o_grant         selected requester
// ---------------------------------------------------------------------------
module ddr_rr_arb
   import ddr_burst_sequencer_pkg::*;
(
   input  logic   clk,
   input  logic   reset,
   input  logic   i_wr_req,
   input  logic   i_rd_req,
   input  logic   i_take,
   output logic   o_valid,
   output grant_e o_grant
);

   grant_e r_last;

   assign o_valid = i_wr_req | i_rd_req;

   always_comb begin
      if (i_wr_req && i_rd_req)
         o_grant = (r_last == GRANT_RD) ? GRANT_WR : GRANT_RD;
      else if (i_wr_req)
         o_grant = GRANT_WR;
      else
         o_grant = GRANT_RD;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_last <= GRANT_RD;
      else if (i_take && o_valid)
         r_last <= o_grant;
   end

endmodule

// File: rtl/ddr_burst_sequencer.sv
// ---------------------------------------------------------------------------
// ddr_burst_sequencer
//   Drives the DDR2 user command/data port for the memory data path.
//   Alternates write bursts (write FIFO -> DDR) and read bursts
//   (DDR -> read FIFO), BURST_LEN single-word commands per grant, and pulses
//   wr_addr_up / rd_addr_up once per accepted command so the address
//   generator steps by 4 bytes.
//   Ports:
//     clk    system clock
//     reset  async active-low reset
//     bus    ddr_burst_sequencer_if.master (FIFO, address and DDR signals)
// ---------------------------------------------------------------------------
module ddr_burst_sequencer
   import ddr_burst_sequencer_pkg::*;
#(
   parameter int BURST_LEN = 8
)(
   input  logic clk,
   input  logic reset,
   ddr_burst_sequencer_if.master bus
);

   localparam int CNT_W = $clog2(BURST_LEN);

   state_e           r_state;
   logic [CNT_W-1:0] r_cnt;

   logic   w_gnt_vld;
   grant_e w_gnt;
   logic   w_take;
   logic   w_last;
   logic   w_wdf_hs;

   assign w_take   = (r_state == ST_IDLE) && !bus.ddr_vaild;
   assign w_last   = (r_cnt == CNT_W'(BURST_LEN - 1));
   assign w_wdf_hs = !bus.wr_fifo_empty && bus.wdf_rdy;

   ddr_rr_arb u_arb (
      .clk      (clk),
      .reset    (reset),
      .i_wr_req (bus.wr_req),
      .i_rd_req (bus.rd_req),
      .i_take   (w_take),
      .o_valid  (w_gnt_vld),
      .o_grant  (w_gnt)
   );

   // Sequencer FSM. ddr_vaild is a restart and overrides every state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else if (bus.ddr_vaild) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: if (w_gnt_vld) begin
               r_cnt   <= '0;
               r_state <= (w_gnt == GRANT_WR) ? ST_WR_DATA : ST_RD_CMD;
            end
            ST_WR_DATA: if (w_wdf_hs) r_state <= ST_WR_CMD;
            ST_WR_CMD: if (bus.cmd_rdy) begin
               r_cnt   <= r_cnt + CNT_W'(1);
               r_state <= w_last ? ST_IDLE : ST_WR_DATA;
            end
            ST_RD_CMD: if (bus.cmd_rdy) r_state <= ST_RD_WAIT;
            ST_RD_WAIT: if (bus.rdata_valid) begin
               r_cnt   <= r_cnt + CNT_W'(1);
               r_state <= w_last ? ST_IDLE : ST_RD_CMD;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Outputs decode the registered state; the strobes qualify with the
   // controller/FIFO handshakes in the same cycle so each accepted beat
   // produces exactly one pop/push/addr_up. A restart masks everything so
   // a handshake coinciding with ddr_vaild is discarded.
   logic              w_wr_fifo_rd, w_rd_fifo_wr, w_rd_addr_up, w_wr_addr_up;
   logic              w_cmd_en, w_wdf_en;
   logic [2:0]        w_cmd_instr;
   logic [ADDR_W-1:0] w_cmd_addr;
   logic [DATA_W-1:0] w_wdf_data, w_rd_fifo_data;

   always_comb begin
      w_wr_fifo_rd   = 1'b0;
      w_rd_fifo_wr   = 1'b0;
      w_rd_addr_up   = 1'b0;
      w_wr_addr_up   = 1'b0;
      w_cmd_en       = 1'b0;
      w_wdf_en       = 1'b0;
      w_cmd_instr    = '0;
      w_cmd_addr     = '0;
      w_wdf_data     = '0;
      w_rd_fifo_data = '0;
      if (!bus.ddr_vaild) begin
         case (r_state)
            ST_WR_DATA: begin
               w_wdf_en     = !bus.wr_fifo_empty;
               w_wdf_data   = bus.wr_fifo_data;
               w_wr_fifo_rd = w_wdf_hs;
            end
            ST_WR_CMD: begin
               w_cmd_en     = 1'b1;
               w_cmd_instr  = CMD_WR;
               w_cmd_addr   = bus.wr_addr;
               w_wr_addr_up = bus.cmd_rdy;
            end
            ST_RD_CMD: begin
               w_cmd_en     = 1'b1;
               w_cmd_instr  = CMD_RD;
               w_cmd_addr   = bus.rd_addr;
               w_rd_addr_up = bus.cmd_rdy;
            end
            ST_RD_WAIT: begin
               w_rd_fifo_wr   = bus.rdata_valid;
               w_rd_fifo_data = bus.rdata;
            end
            default: ;
         endcase
      end
   end

   assign bus.wr_fifo_rd   = w_wr_fifo_rd;
   assign bus.rd_fifo_wr   = w_rd_fifo_wr;
   assign bus.rd_fifo_data = w_rd_fifo_data;
   assign bus.rd_addr_up   = w_rd_addr_up;
   assign bus.wr_addr_up   = w_wr_addr_up;
   assign bus.cmd_en       = w_cmd_en;
   assign bus.cmd_instr    = w_cmd_instr;
   assign bus.cmd_addr     = w_cmd_addr;
   assign bus.wdf_en       = w_wdf_en;
   assign bus.wdf_data     = w_wdf_data;

endmodule

// File: tb/tb_ddr_burst_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ddr_burst_sequencer
//   Directed bench for ddr_burst_sequencer with a small environment model:
//   address generator (+4 per addr_up, reload on ddr_vaild), write FIFO
//   head counter, and a read responder returning 0xA5A50000+n three cycles
//   after each accepted read command.
// ---------------------------------------------------------------------------
module tb_ddr_burst_sequencer;
   import ddr_burst_sequencer_pkg::*;

   localparam logic [31:0] WBASE = 32'hD000_0000;
   localparam logic [31:0] RBASE = 32'hA5A5_0000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ddr_burst_sequencer_if bus();

   ddr_burst_sequencer #(.BURST_LEN(8)) dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   // ---------------- environment model ----------------
   int         rsp_n;
   logic [1:0] rsp_cnt;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.wr_addr      <= '0;
         bus.rd_addr      <= '0;
         bus.wr_fifo_data <= WBASE;
         bus.rdata_valid  <= 1'b0;
         bus.rdata        <= '0;
         rsp_cnt          <= '0;
         rsp_n            <= 0;
      end else begin
         if (bus.ddr_vaild) begin
            bus.wr_addr <= '0;
            bus.rd_addr <= '0;
         end else begin
            if (bus.wr_addr_up) bus.wr_addr <= bus.wr_addr + 24'd4;
            if (bus.rd_addr_up) bus.rd_addr <= bus.rd_addr + 24'd4;
         end
         if (bus.wr_fifo_rd) bus.wr_fifo_data <= bus.wr_fifo_data + 32'd1;
         bus.rdata_valid <= 1'b0;
         if (bus.cmd_en && bus.cmd_rdy && bus.cmd_instr == CMD_RD)
            rsp_cnt <= 2'd2;
         else if (rsp_cnt != 0) begin
            rsp_cnt <= rsp_cnt - 2'd1;
            if (rsp_cnt == 2'd1) begin
               bus.rdata_valid <= 1'b1;
               bus.rdata       <= RBASE + 32'(rsp_n);
               rsp_n           <= rsp_n + 1;
            end
         end
      end
   end

   // ---------------- monitor (mid-cycle sampling) ----------------
   logic [26:0] cmd_q[$];   // {instr, addr}
   logic [31:0] wd_q[$];
   logic [31:0] rd_q[$];
   int n_wfr, n_wup, n_rup, n_rfw, outst, max_outst, both_up;

   always @(negedge clk) begin
      if (!rst_n) begin
         cmd_q.delete(); wd_q.delete(); rd_q.delete();
         n_wfr = 0; n_wup = 0; n_rup = 0; n_rfw = 0;
         outst = 0; max_outst = 0; both_up = 0;
      end else begin
         if (bus.cmd_en && bus.cmd_rdy) cmd_q.push_back({bus.cmd_instr, bus.cmd_addr});
         if (bus.wdf_en && bus.wdf_rdy) wd_q.push_back(bus.wdf_data);
         if (bus.rd_fifo_wr) rd_q.push_back(bus.rd_fifo_data);
         n_wfr += int'(bus.wr_fifo_rd);
         n_wup += int'(bus.wr_addr_up);
         n_rup += int'(bus.rd_addr_up);
         n_rfw += int'(bus.rd_fifo_wr);
         outst = outst + int'(bus.rd_addr_up) - int'(bus.rd_fifo_wr);
         if (outst > max_outst) max_outst = outst;
         if (bus.wr_addr_up && bus.rd_addr_up) both_up++;
      end
   end

   function automatic logic [133:0] outs();
      return {bus.cmd_en, bus.wdf_en, bus.wr_fifo_rd, bus.rd_fifo_wr,
              bus.rd_addr_up, bus.wr_addr_up, bus.cmd_instr, bus.cmd_addr,
              bus.wdf_data, bus.rd_fifo_data, 32'h0};
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      bus.wr_req = 0; bus.rd_req = 0; bus.ddr_vaild = 0;
      bus.cmd_rdy = 1; bus.wdf_rdy = 1; bus.wr_fifo_empty = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic pulse_req(input bit wr);
      @(posedge clk); #1;
      if (wr) bus.wr_req = 1; else bus.rd_req = 1;
      @(posedge clk); #1;
      bus.wr_req = 0; bus.rd_req = 0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      do_reset();
      @(posedge clk); #1 rst_n = 1'b0; bus.wr_req = 1;
      repeat (3) @(negedge clk);
      checks++;
      if (outs() !== '0) begin
         errors++; $display("FAIL reset_outputs: got %h want 0", outs());
      end
      @(posedge clk); #1 bus.wr_req = 0; rst_n = 1'b1;
      repeat (4) @(negedge clk);
      checks++;
      if (bus.cmd_en !== 1'b0 || bus.wdf_en !== 1'b0) begin
         errors++; $display("FAIL reset_idle: cmd_en %b wdf_en %b want 0 0", bus.cmd_en, bus.wdf_en);
      end
      // reset in the middle of a write burst
      pulse_req(1'b1);
      for (int i = 0; i < 50 && n_wup < 2; i++) @(posedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if (outs() !== '0) begin
         errors++; $display("FAIL reset_midburst: got %h want 0", outs());
      end
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (6) @(negedge clk);
      checks++;
      if (bus.cmd_en !== 1'b0 || bus.wdf_en !== 1'b0 || n_wfr != 0) begin
         errors++; $display("FAIL reset_no_resume: cmd_en %b wdf_en %b pops %0d want 0 0 0",
                            bus.cmd_en, bus.wdf_en, n_wfr);
      end
   endtask

   task automatic test_write_burst();
      do_reset();
      pulse_req(1'b1);
      for (int i = 0; i < 200 && n_wup < 8; i++) @(posedge clk);
      repeat (4) @(negedge clk);
      checks++;
      if (n_wup != 8 || n_wfr != 8 || cmd_q.size() != 8) begin
         errors++; $display("FAIL wr_counts: addr_up %0d pops %0d cmds %0d want 8 8 8",
                            n_wup, n_wfr, cmd_q.size());
      end
      for (int i = 0; i < cmd_q.size() && i < 8; i++) begin
         checks++;
         if (cmd_q[i] !== {CMD_WR, 24'(i * 4)}) begin
            errors++; $display("FAIL wr_cmd[%0d]: got %h want %h", i, cmd_q[i], {CMD_WR, 24'(i * 4)});
         end
      end
      for (int i = 0; i < wd_q.size() && i < 8; i++) begin
         checks++;
         if (wd_q[i] !== WBASE + 32'(i)) begin
            errors++; $display("FAIL wr_data[%0d]: got %h want %h", i, wd_q[i], WBASE + 32'(i));
         end
      end
      checks++;
      if (bus.cmd_en !== 1'b0 || bus.wdf_en !== 1'b0) begin
         errors++; $display("FAIL wr_end_idle: cmd_en %b wdf_en %b want 0 0", bus.cmd_en, bus.wdf_en);
      end
   endtask

   task automatic test_arbitration();
      logic [26:0] exp;
      do_reset();
      @(posedge clk); #1 bus.wr_req = 1; bus.rd_req = 1;
      for (int i = 0; i < 800 && cmd_q.size() < 32; i++) @(posedge clk);
      #1 bus.wr_req = 0; bus.rd_req = 0;
      for (int i = 0; i < 50 && rd_q.size() < 16; i++) @(posedge clk);
      repeat (6) @(negedge clk);
      checks++;
      if (cmd_q.size() != 32 || rd_q.size() != 16 || wd_q.size() != 16) begin
         errors++; $display("FAIL arb_counts: cmds %0d rd %0d wr %0d want 32 16 16",
                            cmd_q.size(), rd_q.size(), wd_q.size());
      end
      for (int i = 0; i < cmd_q.size() && i < 32; i++) begin
         exp = {((i / 8) % 2 == 1) ? CMD_RD : CMD_WR, 24'((((i / 16) * 8) + (i % 8)) * 4)};
         checks++;
         if (cmd_q[i] !== exp) begin
            errors++; $display("FAIL arb_cmd[%0d]: got %h want %h", i, cmd_q[i], exp);
         end
      end
      for (int i = 0; i < rd_q.size() && i < 16; i++) begin
         checks++;
         if (rd_q[i] !== RBASE + 32'(i)) begin
            errors++; $display("FAIL arb_rdata[%0d]: got %h want %h", i, rd_q[i], RBASE + 32'(i));
         end
      end
      checks++;
      if (both_up != 0) begin
         errors++; $display("FAIL arb_up_overlap: got %0d want 0", both_up);
      end
   endtask

   task automatic test_cmd_stall();
      do_reset();
      @(posedge clk); #1 bus.cmd_rdy = 0;
      pulse_req(1'b1);
      for (int i = 0; i < 20 && !bus.cmd_en; i++) @(negedge clk);
      for (int s = 0; s < 5; s++) begin
         checks++;
         if (bus.cmd_en !== 1'b1 || bus.cmd_instr !== CMD_WR || bus.cmd_addr !== 24'h0 ||
             bus.wr_addr_up !== 1'b0 || n_wup != 0) begin
            errors++; $display("FAIL stall[%0d]: en %b instr %h addr %h up %b ups %0d want 1 0 0 0 0",
                               s, bus.cmd_en, bus.cmd_instr, bus.cmd_addr, bus.wr_addr_up, n_wup);
         end
         @(negedge clk);
      end
      @(posedge clk); #1 bus.cmd_rdy = 1;
      for (int i = 0; i < 200 && n_wup < 8; i++) @(posedge clk);
      repeat (3) @(negedge clk);
      checks++;
      if (n_wup != 8 || cmd_q.size() != 8) begin
         errors++; $display("FAIL stall_total: ups %0d cmds %0d want 8 8", n_wup, cmd_q.size());
      end
      checks++;
      if (cmd_q.size() > 0 && cmd_q[0] !== {CMD_WR, 24'h0}) begin
         errors++; $display("FAIL stall_first: got %h want %h", cmd_q[0], {CMD_WR, 24'h0});
      end
   endtask

   task automatic test_read_burst();
      do_reset();
      pulse_req(1'b0);
      for (int i = 0; i < 200 && rd_q.size() < 8; i++) @(posedge clk);
      repeat (4) @(negedge clk);
      checks++;
      if (rd_q.size() != 8 || n_rup != 8 || n_wup != 0) begin
         errors++; $display("FAIL rd_counts: pushes %0d rd_up %0d wr_up %0d want 8 8 0",
                            rd_q.size(), n_rup, n_wup);
      end
      for (int i = 0; i < rd_q.size() && i < 8; i++) begin
         checks++;
         if (rd_q[i] !== RBASE + 32'(i)) begin
            errors++; $display("FAIL rd_data[%0d]: got %h want %h", i, rd_q[i], RBASE + 32'(i));
         end
         checks++;
         if (i < cmd_q.size() && cmd_q[i] !== {CMD_RD, 24'(i * 4)}) begin
            errors++; $display("FAIL rd_cmd[%0d]: got %h want %h", i, cmd_q[i], {CMD_RD, 24'(i * 4)});
         end
      end
      checks++;
      if (max_outst > 1) begin
         errors++; $display("FAIL rd_outstanding: got %0d want <=1", max_outst);
      end
   endtask

   task automatic test_fifo_empty();
      do_reset();
      pulse_req(1'b1);
      for (int i = 0; i < 100 && n_wfr < 3; i++) @(posedge clk);
      #1 bus.wr_fifo_empty = 1;
      for (int s = 0; s < 4; s++) begin
         @(negedge clk);
         checks++;
         if (bus.wdf_en !== 1'b0 || bus.wr_fifo_rd !== 1'b0 || n_wfr != 3) begin
            errors++; $display("FAIL empty_hold[%0d]: wdf_en %b pop %b pops %0d want 0 0 3",
                               s, bus.wdf_en, bus.wr_fifo_rd, n_wfr);
         end
      end
      @(posedge clk); #1 bus.wr_fifo_empty = 0;
      for (int i = 0; i < 200 && n_wup < 8; i++) @(posedge clk);
      repeat (3) @(negedge clk);
      checks++;
      if (wd_q.size() != 8 || n_wfr != 8 || n_wup != 8) begin
         errors++; $display("FAIL empty_total: words %0d pops %0d ups %0d want 8 8 8",
                            wd_q.size(), n_wfr, n_wup);
      end
      for (int i = 0; i < wd_q.size() && i < 8; i++) begin
         checks++;
         if (wd_q[i] !== WBASE + 32'(i)) begin
            errors++; $display("FAIL empty_data[%0d]: got %h want %h", i, wd_q[i], WBASE + 32'(i));
         end
      end
   endtask

   task automatic test_abort();
      do_reset();
      pulse_req(1'b0);
      for (int i = 0; i < 50 && n_rup < 1; i++) @(posedge clk);
      #1 bus.ddr_vaild = 1;
      @(negedge clk);
      checks++;
      if (bus.cmd_en !== 1'b0 || bus.rd_fifo_wr !== 1'b0 || bus.rd_addr_up !== 1'b0) begin
         errors++; $display("FAIL abort_mask: cmd_en %b push %b up %b want 0 0 0",
                            bus.cmd_en, bus.rd_fifo_wr, bus.rd_addr_up);
      end
      @(posedge clk); #1 bus.ddr_vaild = 0;
      repeat (10) @(negedge clk);
      checks++;
      if (n_rfw != 0 || n_rup != 1 || cmd_q.size() != 1 || bus.cmd_en !== 1'b0) begin
         errors++; $display("FAIL abort_drop: pushes %0d ups %0d cmds %0d en %b want 0 1 1 0",
                            n_rfw, n_rup, cmd_q.size(), bus.cmd_en);
      end
      // fresh burst after the restart: full 8 words from the reloaded address
      pulse_req(1'b0);
      for (int i = 0; i < 200 && n_rfw < 8; i++) @(posedge clk);
      repeat (4) @(negedge clk);
      checks++;
      if (n_rfw != 8 || n_rup != 9) begin
         errors++; $display("FAIL abort_restart: pushes %0d ups %0d want 8 9", n_rfw, n_rup);
      end
      checks++;
      if (cmd_q.size() > 1 && cmd_q[1] !== {CMD_RD, 24'h0}) begin
         errors++; $display("FAIL abort_addr: got %h want %h", cmd_q[1], {CMD_RD, 24'h0});
      end
      checks++;
      if (rd_q.size() > 0 && rd_q[0] !== RBASE + 32'd1) begin
         errors++; $display("FAIL abort_data: got %h want %h", rd_q[0], RBASE + 32'd1);
      end
   endtask

   initial begin
      bus.wr_req = 0; bus.rd_req = 0; bus.ddr_vaild = 0;
      bus.cmd_rdy = 1; bus.wdf_rdy = 1; bus.wr_fifo_empty = 0;
      test_reset();
      test_write_burst();
      test_arbitration();
      test_cmd_stall();
      test_read_burst();
      test_fifo_empty();
      test_abort();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
